// File: rtl/bcd_time_counter_pkg.sv
// Shared types and limits for the BCD timekeeper.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  typedef enum logic [1:0] {
    SEL_HOUR = 2'd0,
    SEL_MIN  = 2'd1,
    SEL_SEC  = 2'd2,
    SEL_NONE = 2'd3
  } sel_e;

endpackage

// File: rtl/bcd_time_counter_mod_counter.sv
// Two-digit BCD modulo counter (0..MAX). Exposes the next value so the
// parent can compare against the time that is about to be loaded.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic inc,
  input  logic clr,
  output bcd_t tens,
  output bcd_t units,
  output bcd_t nxt_tens,
  output bcd_t nxt_units,
  output logic carry
);

  logic [7:0] value;
  logic       corrupt;
  logic       at_max;

  assign value   = ({4'd0, tens} * 8'd10) + {4'd0, units};
  assign corrupt = (units > 4'd9) || (tens > 4'd9) || (value > 8'(MAX));
  assign at_max  = (value == 8'(MAX));
  assign carry   = inc & ~corrupt & at_max;

  // A corrupted field is reloaded to 00 on its next update instead of advancing.
  always_comb begin
    nxt_tens  = tens;
    nxt_units = units;
    if (clr) begin
      nxt_tens  = 4'd0;
      nxt_units = 4'd0;
    end else if (inc) begin
      if (corrupt || at_max) begin
        nxt_tens  = 4'd0;
        nxt_units = 4'd0;
      end else if (units == 4'd9) begin
        nxt_tens  = tens + 4'd1;
        nxt_units = 4'd0;
      end else begin
        nxt_units = units + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else begin
      tens  <= nxt_tens;
      units <= nxt_units;
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour BCD timekeeper with 1 Hz prescaler and per-field set mode.
// Optional alarm comparator enabled by defining BCD_TIME_ALARM_EN.
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       EN,
  input  logic       SET_MODE,
  input  logic [1:0] SET_SEL,
  input  logic       SET_INC,
`ifdef BCD_TIME_ALARM_EN
  input  logic [3:0] ALM_HOUR1,
  input  logic [3:0] ALM_HOUR0,
  input  logic [3:0] ALM_MIN1,
  input  logic [3:0] ALM_MIN0,
  input  logic       ALM_CLR,
  output logic       ALARM,
`endif
  output logic [3:0] HOUR1,
  output logic [3:0] HOUR0,
  output logic [3:0] MIN1,
  output logic [3:0] MIN0,
  output logic [3:0] SEC1,
  output logic [3:0] SEC0,
  output logic       SEC_TICK
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic          set_inc_q;
  logic          set_edge;
  logic          inc_sec, inc_min, inc_hour;
  logic          sec_carry, min_carry, hour_carry;
  bcd_t          sec_nt, sec_nu, min_nt, min_nu, hour_nt, hour_nu;

  assign tick     = (presc == PRE_TC) & EN & ~SET_MODE;
  assign set_edge = SET_INC & ~set_inc_q & SET_MODE;

  // Carries only ripple on a real tick; set-mode wraps stay inside the field.
  assign inc_sec  = tick | (set_edge & (SET_SEL == SEL_SEC));
  assign inc_min  = (tick & sec_carry) | (set_edge & (SET_SEL == SEL_MIN));
  assign inc_hour = (tick & min_carry) | (set_edge & (SET_SEL == SEL_HOUR));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      presc     <= '0;
      set_inc_q <= 1'b0;
      SEC_TICK  <= 1'b0;
    end else begin
      set_inc_q <= SET_INC;
      SEC_TICK  <= tick;
      if (SET_MODE)
        presc <= '0;
      else if (EN)
        presc <= tick ? '0 : presc + 1'b1;
    end
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .CLK(CLK), .RSTN(RSTN), .inc(inc_sec), .clr(1'b0),
    .tens(SEC1), .units(SEC0), .nxt_tens(sec_nt), .nxt_units(sec_nu),
    .carry(sec_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .CLK(CLK), .RSTN(RSTN), .inc(inc_min), .clr(1'b0),
    .tens(MIN1), .units(MIN0), .nxt_tens(min_nt), .nxt_units(min_nu),
    .carry(min_carry)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .CLK(CLK), .RSTN(RSTN), .inc(inc_hour), .clr(1'b0),
    .tens(HOUR1), .units(HOUR0), .nxt_tens(hour_nt), .nxt_units(hour_nu),
    .carry(hour_carry)
  );

`ifdef BCD_TIME_ALARM_EN
  logic alarm_hit;
  logic unused_alarm;

  // A run-mode tick lands on hh:mm:00 exactly when seconds roll over.
  assign alarm_hit = tick & sec_carry &
                     ({hour_nt, hour_nu, min_nt, min_nu} ==
                      {ALM_HOUR1, ALM_HOUR0, ALM_MIN1, ALM_MIN0});
  assign unused_alarm = ^{sec_nt, sec_nu, hour_carry};

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)
      ALARM <= 1'b0;
    else if (ALM_CLR || SET_MODE)
      ALARM <= 1'b0;
    else if (alarm_hit)
      ALARM <= 1'b1;
  end
`else
  logic unused_nxt;
  assign unused_nxt = ^{sec_nt, sec_nu, min_nt, min_nu, hour_nt, hour_nu, hour_carry};
`endif

endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
- 24-hour BCD timekeeper for the DE2 digital clock.
- Produces the HOUR1/HOUR0, MIN and SEC digit pairs that are consumed by the display, mood-LED and alarm logic.
- Contains a 1 Hz prescaler from CLK and a cascaded sec/min/hour counter.
- Has a set mode for manual adjustment of one field at a time.

Parameters:
- CLK_HZ, 50000000: CLK cycles per second; the prescaler terminal count is CLK_HZ-1. Must be >= 2.

Ports:
- CLK  input  1  system clock
- RSTN  input  1  asynchronous active-low reset
- EN  input  1  run enable; low freezes the time and prescaler (holds their values)
- SET_MODE  input  1  high = adjust mode; time does not advance
- SET_SEL  input  2  field to adjust: 0 = hour, 1 = min, 2 = sec, 3 = none
- SET_INC  input  1  synchronous level; each rising edge increments the selected field in set mode
- HOUR1  output  4  hour tens, 0..2
- HOUR0  output  4  hour units, 0..9 (0..3 when HOUR1=2)
- MIN1  output  4  minute tens, 0..5
- MIN0  output  4  minute units, 0..9
- SEC1  output  4  second tens, 0..5
- SEC0  output  4  second units, 0..9
- SEC_TICK  output  1  one-cycle pulse, registered on the same edge that advances SEC

Behaviour:
- Reset (RSTN low, asynchronous): all digit outputs = 0 (00:00:00), SEC_TICK = 0, prescaler = 0, SET_INC edge register = 0.
- All outputs are registered. No combinational path exists from any input to any output.

Prescaler:
- Counts 0..CLK_HZ-1 while EN=1 and SET_MODE=0.
- tick = (prescaler == CLK_HZ-1) & EN & !SET_MODE.
- On tick, the prescaler returns to 0.

Run mode (SET_MODE=0, EN=1): on the tick edge:
- SEC advances and SEC_TICK is set for exactly one cycle.
- Carry rules:
  - SEC0 9 -> 0 carries into SEC1.
  - SEC 59 -> 00 carries into MIN.
  - MIN 59 -> 00 carries into HOUR.
  - HOUR 23 -> 00.
- 23:59:59 -> 00:00:00 in a single edge.
- Latency: first tick after reset occurs CLK_HZ cycles after RSTN deasserts.

EN=0:
- Prescaler, digits and SEC_TICK hold; SEC_TICK is forced to 0.
- Resumes counting from the held prescaler value.

Set mode (SET_MODE=1):
- Prescaler is held at 0. No ticks occur and SEC_TICK = 0.
- A SET_INC rising edge (previous sample 0, current sample 1) increments the selected field by 1 on that edge.
- The field wraps within itself with no carry: hour 23 -> 00, min 59 -> 00, sec 59 -> 00.
- SET_SEL=3: SET_INC edges are ignored.
- Increments occur regardless of EN.
- The SET_INC edge register samples continuously, in both modes.

Mode transitions:
- Leaving set mode: prescaler restarts from 0; next tick occurs CLK_HZ cycles later.
- Entering set mode on the same edge as a pending tick: set mode wins and no advance happens.

Illegal values:
- Digit registers never hold non-BCD or out-of-range values.
- If corruption is detected (e.g. HOUR1>2), the next update reloads that field to 00.

Optional Feature:
- Macro: BCD_TIME_ALARM_EN.
- Defined:
  - Adds inputs ALM_HOUR1, ALM_HOUR0, ALM_MIN1, ALM_MIN0 (4 bits each) and ALM_CLR (1 bit).
  - Adds output ALARM (1 bit, reset 0).
  - ALARM sets on a run-mode tick edge whose new time equals ALM hh:mm:00.
  - ALARM stays high until ALM_CLR=1 or SET_MODE=1, either of which clears it on the next edge.
  - Clear has priority over a simultaneous set.
- Undefined: no alarm ports and no alarm logic.

Decomposition:
- Package clock_pkg:
  - bcd_t (4-bit) typedef.
  - Constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - SEL_HOUR/SEL_MIN/SEL_SEC/SEL_NONE encodings.
- Sub-module bcd_mod_counter: two-digit BCD counter.
  - Parameter MAX (decimal).
  - Inputs inc and clr; outputs tens, units and carry (carry = inc & value==MAX).
  - Instantiated three times.
- Top level holds the prescaler, SET_INC edge detect, mode muxing and alarm.

Test Plan:
All scenarios use CLK_HZ=4.
- Reset release, EN=1, SET_MODE=0 -> first SEC_TICK on cycle 4; SEC0=1 after 4 cycles, SEC=10 after 40 cycles.
- Preload 23:59:58 via set mode, then run -> 23:59:59 at tick 1, 00:00:00 at tick 2, each with a one-cycle SEC_TICK.
- SET_MODE=1, SET_SEL=0, 25 SET_INC pulses from 00 -> HOUR=01 (wraps after 23), MIN/SEC unchanged, no SEC_TICK.
- SET_SEL=1 at MIN=59, one SET_INC pulse -> MIN=00, HOUR unchanged (no carry). SET_SEL=3 pulses -> no change.
- EN=0 for 10 cycles mid-second (prescaler=2) -> digits hold; after EN=1, next tick after 2 more cycles. RSTN low mid-count -> immediate 00:00:00.
- BCD_TIME_ALARM_EN with alarm 07:30 and time preset 07:29:59 -> ALARM=1 on the tick to 07:30:00. ALM_CLR for one cycle -> ALARM=0; ALARM is not re-set during 07:30:01..59.
